// File: rtl/regfile_arbiter_pkg.sv
// Shared encodings for the register-file port arbiter.
package regfile_arbiter_pkg;

   localparam logic RF_RW_READ  = 1'b1;
   localparam logic RF_RW_WRITE = 1'b0;

   localparam int unsigned LOCK_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_ARB  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

endpackage

// Field idx of width w from a bus packed as {..., field1, field0}
`define RFA_FIELD(bus, idx, w) bus[(idx)*(w) +: (w)]

// File: rtl/regfile_arbiter_if.sv
// Requester-side and RegFile-side signals of the register-file arbiter.
interface regfile_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_W     = 5
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            lock;
   logic [NUM_REQ-1:0]            we;
   logic [NUM_REQ*ADDR_W-1:0]     a_ra;
   logic [NUM_REQ*ADDR_W-1:0]     a_rb;
   logic [NUM_REQ*ADDR_W-1:0]     a_rd;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rvalid;
   logic                          busy;
   logic                          rf_en;
   logic                          rf_rw;
   logic [ADDR_W-1:0]             rf_a_ra;
   logic [ADDR_W-1:0]             rf_a_rb;
   logic [ADDR_W-1:0]             rf_a_rd;
   logic [DATA_WIDTH-1:0]         rf_rd;

   modport master (
      output req, lock, we, a_ra, a_rb, a_rd, wdata,
      input  gnt, rvalid, busy, rf_en, rf_rw, rf_a_ra, rf_a_rb, rf_a_rd, rf_rd
   );

   modport slave (
      input  req, lock, we, a_ra, a_rb, a_rd, wdata,
      output gnt, rvalid, busy, rf_en, rf_rw, rf_a_ra, rf_a_rb, rf_a_rd, rf_rd
   );
endinterface

// File: rtl/regfile_arbiter_rr_pick.sv
// Round-robin pick: first eligible requester at or above ptr, wrapping.
module regfile_arbiter_rr_pick #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] excl,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IDX_W-1:0]   win_idx,
   output logic               any
);

   logic [NUM_REQ-1:0] elig;
   int unsigned        cand;

   assign elig = req & ~excl;

   // Scan from the pointer upward; the first eligible candidate wins
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      any     = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(ptr) + k) % NUM_REQ;
         if (!any && elig[IDX_W'(cand)]) begin
            win_oh[IDX_W'(cand)] = 1'b1;
            win_idx              = IDX_W'(cand);
            any                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates the single RegFile access port between NUM_REQ requesters,
// zero-sweeps the RegFile after reset and returns per-requester rvalid.
module regfile_arbiter
   import regfile_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned MAX_LOCK   = 8
) (
   input  logic             clk,
   input  logic             rst,
   regfile_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                  state, nxt_state;
   logic [ADDR_W-1:0]       init_cnt, nxt_init;
   logic [IDX_W-1:0]        ptr, nxt_ptr;
   logic [IDX_W-1:0]        owner, nxt_owner;
   logic [LOCK_CNT_W-1:0]   lock_cnt, nxt_cnt;
   logic [NUM_REQ-1:0]      rvalid_q;

   logic [NUM_REQ-1:0]      gnt_v;
   logic [IDX_W-1:0]        win;
   logic                    granted;
   logic [NUM_REQ-1:0]      owner_oh;
   logic [NUM_REQ-1:0]      excl;
   logic                    owner_hold;
   logic                    at_cap;
   logic [NUM_REQ-1:0]      pick_oh;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_any;

   logic [ADDR_W-1:0]       ra_f [NUM_REQ];
   logic [ADDR_W-1:0]       rb_f [NUM_REQ];
   logic [ADDR_W-1:0]       rd_f [NUM_REQ];
   logic [DATA_WIDTH-1:0]   wd_f [NUM_REQ];

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   // Unpack the per-requester fields of the packed buses
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign ra_f[g] = `RFA_FIELD(bus.a_ra,  g, ADDR_W);
      assign rb_f[g] = `RFA_FIELD(bus.a_rb,  g, ADDR_W);
      assign rd_f[g] = `RFA_FIELD(bus.a_rd,  g, ADDR_W);
      assign wd_f[g] = `RFA_FIELD(bus.wdata, g, DATA_WIDTH);
   end

   assign owner_oh   = NUM_REQ'(1) << owner;
   assign owner_hold = bus.req[owner] & bus.lock[owner];
   assign at_cap     = lock_cnt >= LOCK_CNT_W'(MAX_LOCK);
   // At the lock cap the owner steps aside unless nobody else is asking
   assign excl       = (state == ST_LOCK && owner_hold && at_cap) ? owner_oh : '0;

   regfile_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req     (bus.req),
      .excl    (excl),
      .ptr     (ptr),
      .win_oh  (pick_oh),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // Grant decision and next-state values
   always_comb begin
      gnt_v     = '0;
      win       = '0;
      granted   = 1'b0;
      nxt_state = state;
      nxt_init  = init_cnt;
      nxt_ptr   = ptr;
      nxt_owner = owner;
      nxt_cnt   = lock_cnt;
      if (state == ST_INIT) begin
         nxt_init = init_cnt + ADDR_W'(1);
         if (init_cnt == '1) nxt_state = ST_ARB;
      end else if (state == ST_LOCK && owner_hold && !at_cap) begin
         gnt_v   = owner_oh;
         win     = owner;
         granted = 1'b1;
         nxt_cnt = lock_cnt + LOCK_CNT_W'(1);
      end else if (state == ST_LOCK && owner_hold) begin
         nxt_state = ST_ARB;
         nxt_cnt   = '0;
         granted   = 1'b1;
         if (pick_any) begin
            gnt_v = pick_oh;
            win   = pick_idx;
         end else begin
            gnt_v = owner_oh;
            win   = owner;
         end
         nxt_ptr = next_idx(win);
      end else begin
         // Plain arbitration, also taken the cycle a lock owner lets go
         nxt_state = ST_ARB;
         nxt_cnt   = '0;
         if (pick_any) begin
            gnt_v   = pick_oh;
            win     = pick_idx;
            granted = 1'b1;
            nxt_ptr = next_idx(pick_idx);
            if (bus.lock[pick_idx]) begin
               nxt_state = ST_LOCK;
               nxt_owner = pick_idx;
               nxt_cnt   = LOCK_CNT_W'(1);
            end
         end
      end
   end

   // State, sweep counter, pointer, lock tracking and read-return register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         ptr      <= '0;
         owner    <= '0;
         lock_cnt <= '0;
         rvalid_q <= '0;
      end else begin
         state    <= nxt_state;
         init_cnt <= nxt_init;
         ptr      <= nxt_ptr;
         owner    <= nxt_owner;
         lock_cnt <= nxt_cnt;
         rvalid_q <= gnt_v & ~bus.we;
      end
   end

   // RegFile command: sweep write, granted access, or idle
   always_comb begin
      bus.rf_en   = 1'b0;
      bus.rf_rw   = RF_RW_READ;
      bus.rf_a_ra = '0;
      bus.rf_a_rb = '0;
      bus.rf_a_rd = '0;
      bus.rf_rd   = '0;
      if (rst) begin
         bus.rf_en = 1'b0;
      end else if (state == ST_INIT) begin
         bus.rf_en   = 1'b1;
         bus.rf_rw   = RF_RW_WRITE;
         bus.rf_a_rd = init_cnt;
      end else if (granted) begin
         bus.rf_en   = 1'b1;
         bus.rf_rw   = bus.we[win] ? RF_RW_WRITE : RF_RW_READ;
         bus.rf_a_ra = ra_f[win];
         bus.rf_a_rb = rb_f[win];
         bus.rf_a_rd = rd_f[win];
         bus.rf_rd   = wd_f[win];
      end
   end

   assign bus.gnt    = rst ? '0 : gnt_v;
   assign bus.rvalid = rvalid_q;
   assign bus.busy   = rst | (state == ST_INIT);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter with a behavioural RegFile.
module tb_regfile_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_W(AW)) bif ();

   regfile_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_W(AW), .MAX_LOCK(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   // Behavioural RegFile: write at the edge, registered dual read
   logic [DW-1:0] rf_mem [2**AW];
   logic [DW-1:0] rf_ra, rf_rb;
   always @(posedge clk) begin
      if (bif.rf_en) begin
         if (bif.rf_rw == 1'b0) rf_mem[bif.rf_a_rd] <= bif.rf_rd;
         else begin
            rf_ra <= rf_mem[bif.rf_a_ra];
            rf_rb <= rf_mem[bif.rf_a_rb];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_port(input int i, input logic w, input logic [AW-1:0] ra,
                           input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                           input logic [DW-1:0] d);
      bif.we[i]               = w;
      bif.a_ra[i*AW +: AW]    = ra;
      bif.a_rb[i*AW +: AW]    = rb;
      bif.a_rd[i*AW +: AW]    = rd;
      bif.wdata[i*DW +: DW]   = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bif.req = '0; bif.lock = '0; bif.we = '0;
      for (int i = 0; i < NR; i++) set_port(i, 1'b0, AW'(i), AW'(i + 8), AW'(0), 32'h0);
      next_cycle(); next_cycle();
      bif.req = 4'b1111;
      settle();
      checks++;
      if (bif.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bif.gnt); end
      checks++;
      if (bif.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bif.busy); end
      checks++;
      if (bif.rf_en !== 1'b0) begin errors++; $display("FAIL reset_rf_en: got %b want 0", bif.rf_en); end
      checks++;
      if (bif.rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b want 0000", bif.rvalid); end
      rst = 1'b0;
      settle();
      for (int c = 0; c < 32; c++) begin
         checks++;
         if (bif.gnt !== 4'b0000 || bif.busy !== 1'b1 || bif.rf_en !== 1'b1 ||
             bif.rf_rw !== 1'b0 || bif.rf_a_rd !== AW'(c) || bif.rf_rd !== 32'h0) begin
            errors++;
            $display("FAIL sweep_%0d: gnt=%b busy=%b en=%b rw=%b a_rd=%0d rd=%h want gnt=0000 busy=1 en=1 rw=0 a_rd=%0d rd=0",
                     c, bif.gnt, bif.busy, bif.rf_en, bif.rf_rw, bif.rf_a_rd, bif.rf_rd, c);
         end
         next_cycle();
      end
      settle();
      checks++;
      if (bif.gnt !== 4'b0001 || bif.busy !== 1'b0) begin
         errors++;
         $display("FAIL first_grant: gnt=%b busy=%b want gnt=0001 busy=0", bif.gnt, bif.busy);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]    exp_g, exp_v;
      logic [AW-1:0] exp_ra, exp_rb;
      for (int k = 0; k < 5; k++) begin
         exp_g  = 4'b0001 << (k % 4);
         exp_v  = (k == 0) ? 4'b0000 : 4'b0001 << ((k - 1) % 4);
         exp_ra = AW'(k % 4);
         exp_rb = AW'(k % 4 + 8);
         checks++;
         if (bif.gnt !== exp_g || bif.rvalid !== exp_v || bif.rf_en !== 1'b1 ||
             bif.rf_rw !== 1'b1 || bif.rf_a_ra !== exp_ra || bif.rf_a_rb !== exp_rb) begin
            errors++;
            $display("FAIL rr_%0d: gnt=%b rvalid=%b en=%b rw=%b ra=%0d rb=%0d want gnt=%b rvalid=%b en=1 rw=1 ra=%0d rb=%0d",
                     k, bif.gnt, bif.rvalid, bif.rf_en, bif.rf_rw, bif.rf_a_ra, bif.rf_a_rb,
                     exp_g, exp_v, exp_ra, exp_rb);
         end
         next_cycle(); settle();
      end
      bif.req = 4'b0000;
      settle();
      checks++;
      if (bif.gnt !== 4'b0000 || bif.rf_en !== 1'b0 || bif.rf_a_ra !== '0 || bif.rvalid !== 4'b0001) begin
         errors++;
         $display("FAIL rr_idle: gnt=%b en=%b ra=%0d rvalid=%b want gnt=0000 en=0 ra=0 rvalid=0001",
                  bif.gnt, bif.rf_en, bif.rf_a_ra, bif.rvalid);
      end
      next_cycle(); settle();
      checks++;
      if (bif.rvalid !== 4'b0000) begin errors++; $display("FAIL rr_rvalid_clear: got %b want 0000", bif.rvalid); end
   endtask

   task automatic test_hazard();
      set_port(2, 1'b1, AW'(0), AW'(0), AW'(7), 32'hDEADBEEF);
      bif.req = 4'b0100;
      settle();
      checks++;
      if (bif.gnt !== 4'b0100 || bif.rf_en !== 1'b1 || bif.rf_rw !== 1'b0 ||
          bif.rf_a_rd !== AW'(7) || bif.rf_rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL hz_write: gnt=%b en=%b rw=%b a_rd=%0d rd=%h want gnt=0100 en=1 rw=0 a_rd=7 rd=deadbeef",
                  bif.gnt, bif.rf_en, bif.rf_rw, bif.rf_a_rd, bif.rf_rd);
      end
      next_cycle();
      set_port(1, 1'b0, AW'(7), AW'(0), AW'(0), 32'h0);
      bif.req = 4'b0010;
      settle();
      checks++;
      if (bif.gnt !== 4'b0010 || bif.rf_rw !== 1'b1 || bif.rf_a_ra !== AW'(7) ||
          bif.rf_a_rb !== AW'(0) || bif.rvalid !== 4'b0000) begin
         errors++;
         $display("FAIL hz_read: gnt=%b rw=%b ra=%0d rb=%0d rvalid=%b want gnt=0010 rw=1 ra=7 rb=0 rvalid=0000",
                  bif.gnt, bif.rf_rw, bif.rf_a_ra, bif.rf_a_rb, bif.rvalid);
      end
      next_cycle();
      bif.req = 4'b0000;
      settle();
      checks++;
      if (bif.rvalid !== 4'b0010 || rf_ra !== 32'hDEADBEEF || rf_rb !== 32'h0) begin
         errors++;
         $display("FAIL hz_return: rvalid=%b ra=%h rb=%h want rvalid=0010 ra=deadbeef rb=00000000",
                  bif.rvalid, rf_ra, rf_rb);
      end
      set_port(2, 1'b0, AW'(2), AW'(10), AW'(0), 32'h0);
   endtask

   task automatic test_lock_cap();
      logic [3:0] exp_after [3];
      exp_after[0] = 4'b0100; exp_after[1] = 4'b1000; exp_after[2] = 4'b0001;
      bif.req  = 4'b0010;
      bif.lock = 4'b0010;
      settle();
      checks++;
      if (bif.gnt !== 4'b0010) begin errors++; $display("FAIL lock_first: got %b want 0010", bif.gnt); end
      for (int j = 1; j < 8; j++) begin
         next_cycle();
         bif.req = 4'b1111;
         settle();
         checks++;
         if (bif.gnt !== 4'b0010) begin errors++; $display("FAIL lock_hold_%0d: got %b want 0010", j, bif.gnt); end
      end
      for (int j = 0; j < 3; j++) begin
         next_cycle(); settle();
         checks++;
         if (bif.gnt !== exp_after[j]) begin
            errors++;
            $display("FAIL lock_cap_%0d: got %b want %b", j, bif.gnt, exp_after[j]);
         end
      end
      next_cycle();
      bif.req = 4'b0000; bif.lock = 4'b0000;
      settle();
      checks++;
      if (bif.gnt !== 4'b0000) begin errors++; $display("FAIL lock_cap_idle: got %b want 0000", bif.gnt); end
   endtask

   task automatic test_lock_drop();
      bif.req  = 4'b1111;
      bif.lock = 4'b0010;
      settle();
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (bif.gnt !== 4'b0010) begin errors++; $display("FAIL drop_locked_%0d: got %b want 0010", j, bif.gnt); end
         next_cycle();
      end
      bif.lock = 4'b0000;
      settle();
      checks++;
      if (bif.gnt !== 4'b0100 || bif.rf_en !== 1'b1 || bif.rvalid !== 4'b0010) begin
         errors++;
         $display("FAIL drop_switch: gnt=%b en=%b rvalid=%b want gnt=0100 en=1 rvalid=0010",
                  bif.gnt, bif.rf_en, bif.rvalid);
      end
      next_cycle(); settle();
      checks++;
      if (bif.gnt !== 4'b1000) begin errors++; $display("FAIL drop_next: got %b want 1000", bif.gnt); end
      next_cycle();
      bif.req = 4'b0000;
      settle();
      checks++;
      if (bif.gnt !== 4'b0000) begin errors++; $display("FAIL drop_idle: got %b want 0000", bif.gnt); end
   endtask

   task automatic test_reset_mid();
      bif.req = 4'b0001;
      settle();
      checks++;
      if (bif.gnt !== 4'b0001) begin errors++; $display("FAIL rm_grant: got %b want 0001", bif.gnt); end
      #2;
      rst = 1'b1;
      settle();
      checks++;
      if (bif.gnt !== 4'b0000) begin errors++; $display("FAIL rm_gnt_in_rst: got %b want 0000", bif.gnt); end
      next_cycle();
      bif.req = 4'b1111;
      settle();
      checks++;
      if (bif.rvalid !== 4'b0000 || bif.busy !== 1'b1 || bif.gnt !== 4'b0000 || bif.rf_en !== 1'b0) begin
         errors++;
         $display("FAIL rm_held: rvalid=%b busy=%b gnt=%b en=%b want rvalid=0000 busy=1 gnt=0000 en=0",
                  bif.rvalid, bif.busy, bif.gnt, bif.rf_en);
      end
      rst = 1'b0;
      settle();
      checks++;
      if (bif.rf_en !== 1'b1 || bif.rf_rw !== 1'b0 || bif.rf_a_rd !== AW'(0) || bif.busy !== 1'b1) begin
         errors++;
         $display("FAIL rm_sweep_start: en=%b rw=%b a_rd=%0d busy=%b want en=1 rw=0 a_rd=0 busy=1",
                  bif.rf_en, bif.rf_rw, bif.rf_a_rd, bif.busy);
      end
      for (int c = 1; c < 32; c++) begin
         next_cycle(); settle();
         checks++;
         if (bif.rf_a_rd !== AW'(c) || bif.rvalid !== 4'b0000 || bif.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rm_sweep_%0d: a_rd=%0d rvalid=%b gnt=%b want a_rd=%0d rvalid=0000 gnt=0000",
                     c, bif.rf_a_rd, bif.rvalid, bif.gnt, c);
         end
      end
      next_cycle(); settle();
      checks++;
      if (bif.gnt !== 4'b0001 || bif.busy !== 1'b0) begin
         errors++;
         $display("FAIL rm_first_grant: gnt=%b busy=%b want gnt=0001 busy=0", bif.gnt, bif.busy);
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_round_robin();
      test_hazard();
      test_lock_cap();
      test_lock_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single access port of the sample-rate-converter register file between NUM_REQ requesters, e.g. coefficient loader, MAC read path, state write-back, host.
- Each granted request becomes one RegFile cycle: a write, or a dual read.
- After reset, sweeps zeros through every register before any requester is served.
- Handles read-data latency: returns a per-requester rvalid aligned with the registered ra/rb.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, register width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.
- MAX_LOCK, 8, maximum consecutive grants to one locked requester (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  request, one bit per requester
- lock  in  NUM_REQ  owner wants to keep the port next cycle (burst)
- we  in  NUM_REQ  1=write, 0=dual read
- a_ra  in  NUM_REQ*ADDR_W  read address A; requester i at bits [i*ADDR_W +: ADDR_W]
- a_rb  in  NUM_REQ*ADDR_W  read address B, packed the same way
- a_rd  in  NUM_REQ*ADDR_W  write address, packed the same way
- wdata  in  NUM_REQ*DATA_WIDTH  write data, packed the same way
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as issue
- rvalid  out  NUM_REQ  one-hot; ra/rb valid for that requester
- busy  out  1  init sweep in progress
- rf_en  out  1  to RegFile en
- rf_rw  out  1  to RegFile rw; 1=read, 0=write
- rf_a_ra  out  ADDR_W  to RegFile a_ra
- rf_a_rb  out  ADDR_W  to RegFile a_rb
- rf_a_rd  out  ADDR_W  to RegFile a_rd
- rf_rd  out  DATA_WIDTH  to RegFile rd

Behaviour:
- States: INIT, ARB, LOCK.
- Reset (rst=1 at edge):
  - state=INIT, init counter=0, rr pointer=0, lock counter=0, rvalid=0.
  - While rst is held: busy=1, gnt=0, rf_en=0.
- INIT:
  - busy=1; rf_en=1, rf_rw=0, rf_a_rd=counter, rf_rd=0; gnt=0.
  - Counter increments each cycle; after address 2**ADDR_W-1 is written, go to ARB.
  - Sweep takes exactly 2**ADDR_W cycles; the first grant is possible in cycle 2**ADDR_W after reset release.
- ARB:
  - Round-robin: winner = first i with req[i]=1, searching from pointer upward and wrapping at NUM_REQ.
  - gnt[winner]=1 combinationally; rf_en=1; rf_rw=~we[winner]; the winner's address and data fields are muxed onto the rf_* outputs.
  - No request: gnt=0, rf_en=0, rf_* addresses and data=0.
  - After a grant, pointer=winner+1 mod NUM_REQ.
  - If lock[winner]=1: go to LOCK, owner=winner, lock counter=1.
- LOCK:
  - If req[owner]&lock[owner] and lock counter<MAX_LOCK: grant owner regardless of others; counter+1.
  - If owner drops req or lock: behave as ARB this same cycle (no dead cycle) and return to ARB.
  - If counter reaches MAX_LOCK: arbitrate with the owner excluded this cycle; the owner is granted only if no one else requests. Return to ARB.
  - Pointer is unchanged while the owner holds the port.
- Handshake:
  - Requester holds req and its fields stable until it sees gnt.
  - One access per grant cycle; back-to-back grants to the same requester are allowed.
- Read return:
  - rvalid[i]=1 in cycle N+1 iff requester i was granted a read in cycle N.
  - The requester samples the shared RegFile ra/rb in that cycle.
  - Writes produce no rvalid.
- Hazards:
  - Write in cycle N then read of the same address in cycle N+1 returns the new data (RegFile writes at the edge).
  - No bypass is provided or needed.
- Reset mid-operation:
  - Pending rvalid is cleared, the lock is abandoned and the sweep restarts from address 0.
  - A grant issued in the reset cycle is not honoured.
- we, lock and field values of non-requesting ports are ignored.

Decomposition:
- Shared package/header holds: RF_RW_READ=1 and RF_RW_WRITE=0 encodings, state encodings (INIT/ARB/LOCK), and field-slicing macros for the packed buses.
- One sub-module is natural: rr_pick. It is purely combinational: given req, pointer and an exclude mask, it returns a one-hot winner and the winner index.

Test Plan:
1. Reset with ADDR_W=5, then hold all req=1 -> gnt=0, busy=1 and rf_en=1 writing zeros to addresses 0..31 over 32 cycles; first gnt in cycle 32, to requester 0.
2. req=4'b1111, lock=0, all reads -> gnt sequence 0,1,2,3,0; each rvalid one cycle after its gnt; rf_rw=1 throughout.
3. Requester 2 writes 0xDEADBEEF to r7 in cycle N; requester 1 reads a_ra=7, a_rb=0 in cycle N+1 -> rvalid[1] in N+2 with ra=0xDEADBEEF, rb=0.
4. Requester 1 holds req=lock=1 while 0,2,3 request, MAX_LOCK=8 -> eight consecutive gnt[1], then gnt[2], with 1 not granted while others wait.
5. Owner drops lock after 3 locked grants -> next cycle arbitrates immediately to the next requester above the owner; no idle cycle.
6. Assert rst one cycle after a read grant -> rvalid stays 0, busy=1, sweep restarts at address 0.
